rf_agc_ctrl: RTL and testbench

Automatic gain control loop controller for the RF gain path. It measures the mean absolute level of the 16-bit stream leaving the gain multiplier and produces the 32-bit scale word that the multiplier consumes. It therefore closes the loop around the gain block: measure over a window, compare against a programmable target, step the scale up or down, and clamp it. It sits between the gain block output and the gain block `scale` input, alongside the AXI register interface that supplies target and control.

---
 rtl/rf_gain_pkg.sv | 21 ++
 rtl/rf_abs_accum.sv | 40 ++++
 rtl/rf_agc_ctrl.sv | 153 +++++++++++++++
 tb/tb_rf_agc_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_gain_pkg.sv
// Shared types and constants for the RF gain path: sample/scale widths,
// unity scale word, AGC state encoding and the sample magnitude helper.
package rf_gain_pkg;

  localparam int SCALE_W  = 32;
  localparam int SAMPLE_W = 16;
  localparam logic [SCALE_W-1:0] SCALE_UNITY = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    DECIDE
  } agc_state_t;

  // -32768 maps onto 16'h8000, which is exact when read as unsigned.
  function automatic logic [SAMPLE_W-1:0] abs_sample(input logic [SAMPLE_W-1:0] x);
    return x[SAMPLE_W-1] ? ((~x) + SAMPLE_W'(1)) : x;
  endfunction

endpackage

// File: rtl/rf_abs_accum.sv
// Window accumulator of |sample| with a sample counter; o_done marks the
// sample that completes a 2^WIN_LOG2 window, o_level is the truncated mean.
module rf_abs_accum
  import rf_gain_pkg::*;
#(
  parameter int WIN_LOG2 = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_done,
  output logic [SAMPLE_W-1:0] o_level
);

  localparam int ACC_W = SAMPLE_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  logic [ACC_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [SAMPLE_W-1:0] w_abs;

  assign w_abs = abs_sample(i_sample);

  // Full-window sum of 16-bit magnitudes fits in ACC_W bits, so no overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_abs);
      r_cnt <= r_cnt + WIN_LOG2'(1);
    end
  end

  assign o_done  = i_en && (r_cnt == CNT_LAST);
  assign o_level = r_acc[ACC_W-1:WIN_LOG2];

endmodule

// File: rtl/rf_agc_ctrl.sv
// AGC loop controller: measures mean |x| per window, compares against the
// target and steps/clamps the scale word fed back to the gain multiplier.
module rf_agc_ctrl
  import rf_gain_pkg::*;
#(
  parameter int                 WIN_LOG2   = 10,
  parameter int                 SETTLE_CYC = 4,
  parameter int                 STEP_SHIFT = 4,
  parameter logic [SCALE_W-1:0] SCALE_INIT = 32'h0001_0000,
  parameter logic [SCALE_W-1:0] SCALE_MIN  = 32'h0000_0100,
  parameter logic [SCALE_W-1:0] SCALE_MAX  = 32'h1FFF_FFFF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_hold,
  input  logic [SAMPLE_W-1:0] i_stream_in,
  input  logic [SAMPLE_W-1:0] i_target,
  input  logic [SAMPLE_W-1:0] i_deadband,
  output logic [SCALE_W-1:0]  o_scale,
  output logic                o_scale_valid,
  output logic [SAMPLE_W-1:0] o_level,
  output logic                o_locked,
  output logic                o_at_min,
  output logic                o_at_max
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  agc_state_t r_state;
  agc_state_t w_next;
  logic       w_clear;
  logic       w_acc_en;
  logic       w_decide;
  logic       w_done;
  logic [7:0] r_settle_cnt;

  logic [SAMPLE_W-1:0] w_level;
  logic [SAMPLE_W:0]   w_err;
  logic                w_locked;
  logic [SCALE_W-1:0]  w_step_raw;
  logic [SCALE_W-1:0]  w_step;
  logic [SCALE_W:0]    w_up;
  logic [SCALE_W:0]    w_down;
  logic [SCALE_W:0]    w_cand;
  logic [SCALE_W-1:0]  w_new_scale;

  logic [SCALE_W-1:0]  r_scale;
  logic                r_valid;
  logic [SAMPLE_W-1:0] r_level;
  logic                r_locked;
  logic                r_at_min;
  logic                r_at_max;

  rf_abs_accum #(
    .WIN_LOG2(WIN_LOG2)
  ) u_accum (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_clear),
    .i_en     (w_acc_en),
    .i_sample (i_stream_in),
    .o_done   (w_done),
    .o_level  (w_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Dropping enable wins over every transition and discards a partial window.
  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b1;
    w_acc_en = 1'b0;
    w_decide = 1'b0;
    unique case (r_state)
      IDLE:   if (i_enable) w_next = SETTLE;
      SETTLE: if (r_settle_cnt == SETTLE_LAST) w_next = ACCUM;
      ACCUM: begin
        w_clear  = 1'b0;
        w_acc_en = 1'b1;
        if (w_done) w_next = DECIDE;
      end
      DECIDE: begin
        w_decide = 1'b1;
        w_next   = SETTLE;
      end
      default: w_next = IDLE;
    endcase
    if (!i_enable) begin
      w_next   = IDLE;
      w_clear  = 1'b1;
      w_acc_en = 1'b0;
      w_decide = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != SETTLE)) r_settle_cnt <= '0;
    else                              r_settle_cnt <= r_settle_cnt + 8'd1;
  end

  assign w_err = (w_level >= i_target) ? ({1'b0, w_level} - {1'b0, i_target})
                                       : ({1'b0, i_target} - {1'b0, w_level});
  assign w_locked = (w_err <= {1'b0, i_deadband});

  assign w_step_raw = r_scale >> STEP_SHIFT;
  assign w_step     = (w_step_raw == '0) ? SCALE_W'(1) : w_step_raw;
  assign w_up       = {1'b0, r_scale} + {1'b0, w_step};
  assign w_down     = (r_scale >= w_step) ? ({1'b0, r_scale} - {1'b0, w_step}) : '0;

  // One extra bit of headroom lets the clamp see values beyond the 32-bit range.
  always_comb begin
    w_cand = {1'b0, r_scale};
    if (!w_locked && !i_hold) begin
      if (w_level < i_target) w_cand = w_up;
      else                    w_cand = w_down;
    end
    if (w_cand < {1'b0, SCALE_MIN})      w_new_scale = SCALE_MIN;
    else if (w_cand > {1'b0, SCALE_MAX}) w_new_scale = SCALE_MAX;
    else                                 w_new_scale = w_cand[SCALE_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scale  <= SCALE_INIT;
      r_valid  <= 1'b0;
      r_level  <= '0;
      r_locked <= 1'b0;
      r_at_min <= (SCALE_INIT == SCALE_MIN);
      r_at_max <= (SCALE_INIT == SCALE_MAX);
    end else begin
      r_valid <= w_decide;
      if (w_decide) begin
        r_scale  <= w_new_scale;
        r_level  <= w_level;
        r_locked <= w_locked;
        r_at_min <= (w_new_scale == SCALE_MIN);
        r_at_max <= (w_new_scale == SCALE_MAX);
      end
    end
  end

  assign o_scale       = r_scale;
  assign o_scale_valid = r_valid;
  assign o_level       = r_level;
  assign o_locked      = r_locked;
  assign o_at_min      = r_at_min;
  assign o_at_max      = r_at_max;

endmodule

// File: tb/tb_rf_agc_ctrl.sv
// Self-checking bench for rf_agc_ctrl: scenario tasks plus randomized windows
// compared against an arithmetic model of the AGC rules.
module tb_rf_agc_ctrl;

  localparam int     WIN_LOG2   = 4;
  localparam int     SETTLE_CYC = 4;
  localparam int     STEP_SHIFT = 4;
  localparam int     WIN        = 1 << WIN_LOG2;
  localparam int     PERIOD     = SETTLE_CYC + WIN + 1;
  localparam longint SCALE_INIT = 64'h0001_0000;
  localparam longint SCALE_MIN  = 64'h0000_0100;
  localparam longint SCALE_MAX  = 64'h1FFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_hold = 1'b0;
  logic [15:0] i_stream_in = '0;
  logic [15:0] i_target = '0;
  logic [15:0] i_deadband = '0;
  logic [31:0] o_scale;
  logic        o_scale_valid;
  logic [15:0] o_level;
  logic        o_locked;
  logic        o_at_min;
  logic        o_at_max;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_agc_ctrl #(
    .WIN_LOG2   (WIN_LOG2),
    .SETTLE_CYC (SETTLE_CYC),
    .STEP_SHIFT (STEP_SHIFT),
    .SCALE_INIT (32'h0001_0000),
    .SCALE_MIN  (32'h0000_0100),
    .SCALE_MAX  (32'h1FFF_FFFF)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_hold        (i_hold),
    .i_stream_in   (i_stream_in),
    .i_target      (i_target),
    .i_deadband    (i_deadband),
    .o_scale       (o_scale),
    .o_scale_valid (o_scale_valid),
    .o_level       (o_level),
    .o_locked      (o_locked),
    .o_at_min      (o_at_min),
    .o_at_max      (o_at_max)
  );

  // Reference rules, expressed as plain integer arithmetic.
  function automatic int model_abs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit model_locked(input int lvl, input int tgt, input int db);
    return model_abs(lvl - tgt) <= db;
  endfunction

  function automatic longint model_next(input longint s, input int lvl, input int tgt,
                                        input int db, input bit hd);
    longint step;
    longint v;
    step = s / (64'd1 << STEP_SHIFT);
    if (step < 1) step = 1;
    if (model_locked(lvl, tgt, db) || hd) v = s;
    else if (lvl < tgt)                   v = s + step;
    else                                  v = s - step;
    if (v < SCALE_MIN) v = SCALE_MIN;
    if (v > SCALE_MAX) v = SCALE_MAX;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_enable = 1'b0;
    i_hold = 1'b0;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (o_scale !== 32'h0001_0000) begin
      miscompares++;
      $display("[TB] FAIL reset_scale: got %h, expected %h", o_scale, 32'h0001_0000);
    end
    vectors++;
    if ({o_scale_valid, o_level, o_locked, o_at_min, o_at_max} !== 20'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got valid=%b level=%0d locked=%b min=%b max=%b, expected all 0",
               o_scale_valid, o_level, o_locked, o_at_min, o_at_max);
    end
  endtask

  task automatic test_lock();
    int cyc = 0;
    bit seen = 0;
    do_reset();
    i_stream_in = 16'd1000;
    i_target = 16'd1000;
    i_deadband = 16'd16;
    i_enable = 1'b1;
    tick();
    while (!seen && cyc < 200) begin
      tick();
      cyc++;
      seen = o_scale_valid;
    end
    vectors++;
    if (!seen || cyc != PERIOD) begin
      miscompares++;
      $display("[TB] FAIL lock_first_pulse: got %0d cycles (seen=%b), expected %0d", cyc, seen, PERIOD);
    end
    vectors++;
    if ({o_level, o_locked, o_scale} !== {16'd1000, 1'b1, 32'h0001_0000}) begin
      miscompares++;
      $display("[TB] FAIL lock_result: got level=%0d locked=%b scale=%h, expected 1000 1 00010000",
               o_level, o_locked, o_scale);
    end
    tick();
    vectors++;
    if (o_scale_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lock_pulse_width: got valid=%b, expected 0", o_scale_valid);
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_open_loop();
    int cyc;
    bit seen;
    longint exp_s = SCALE_INIT;
    do_reset();
    i_stream_in = 16'd500;
    i_target = 16'd1000;
    i_deadband = 16'd0;
    i_enable = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
        tick();
        cyc++;
        seen = o_scale_valid;
      end
      exp_s = model_next(exp_s, 500, 1000, 0, 1'b0);
      vectors++;
      if (!seen || cyc != PERIOD) begin
        miscompares++;
        $display("[TB] FAIL open_period[%0d]: got %0d cycles (seen=%b), expected %0d", p, cyc, seen, PERIOD);
      end
      vectors++;
      if ({o_scale, o_level, o_locked, o_at_min, o_at_max} !== {32'(exp_s), 16'd500, 3'b000}) begin
        miscompares++;
        $display("[TB] FAIL open_step[%0d]: got scale=%h level=%0d locked=%b, expected scale=%h level=500 locked=0",
                 p, o_scale, o_level, o_locked, 32'(exp_s));
      end
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_min_clamp();
    int cyc;
    bit seen;
    int sat = 0;
    longint exp_s = SCALE_INIT;
    do_reset();
    i_stream_in = 16'h8000;
    i_target = 16'd100;
    i_deadband = 16'd0;
    i_enable = 1'b1;
    tick();
    for (int p = 0; p < 200 && sat < 3; p++) begin
      cyc = 0;
      seen = 0;
      while (!seen && cyc < PERIOD + 5) begin
        tick();
        cyc++;
        seen = o_scale_valid;
      end
      if (!seen) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL min_timeout: no pulse within %0d cycles at pulse %0d", PERIOD + 5, p);
        break;
      end
      exp_s = model_next(exp_s, 32768, 100, 0, 1'b0);
      vectors++;
      if (o_scale !== 32'(exp_s) || o_level !== 16'h8000 || o_at_min !== (exp_s == SCALE_MIN)) begin
        miscompares++;
        $display("[TB] FAIL min_step[%0d]: got scale=%h level=%h at_min=%b, expected scale=%h level=8000 at_min=%b",
                 p, o_scale, o_level, o_at_min, 32'(exp_s), exp_s == SCALE_MIN);
      end
      if (exp_s == SCALE_MIN) sat++;
    end
    vectors++;
    if (sat < 3 || o_scale !== 32'h0000_0100 || o_at_min !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL min_saturation: got scale=%h at_min=%b pulses_at_min=%0d, expected 00000100 1 3",
               o_scale, o_at_min, sat);
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_closed_loop();
    logic [15:0] pipe [3];
    int          x = 300;
    longint      prod;
    longint      s = SCALE_INIT;
    longint      pos;
    longint      neg;
    longint      d;
    int          lvl;
    bit          lk = 0;
    bit          seen;
    int          cyc;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    do_reset();
    i_target = 16'd3000;
    i_deadband = 16'd16;
    i_enable = 1'b1;
    for (int p = 0; p < 80 && !lk; p++) begin
      cyc = 0;
      seen = 0;
      while (!seen && cyc < PERIOD + 5) begin
        i_stream_in = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        prod = longint'(x) * longint'(o_scale);
        prod = prod >>> 16;
        pipe[0] = 16'(prod);
        x = -x;
        tick();
        cyc++;
        seen = o_scale_valid;
      end
      if (!seen) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL loop_timeout: no pulse within %0d cycles at pulse %0d", PERIOD + 5, p);
        break;
      end
      pos = (longint'(300) * s) >>> 16;
      neg = (longint'(-300) * s) >>> 16;
      lvl = int'(((WIN / 2) * model_abs(int'(pos)) + (WIN / 2) * model_abs(int'(neg))) / WIN);
      lk = model_locked(lvl, 3000, 16);
      s = model_next(s, lvl, 3000, 16, 1'b0);
      vectors++;
      if (o_level !== 16'(lvl) || o_locked !== lk || o_scale !== 32'(s)) begin
        miscompares++;
        $display("[TB] FAIL loop_step[%0d]: got level=%0d locked=%b scale=%h, expected level=%0d locked=%b scale=%h",
                 p, o_level, o_locked, o_scale, lvl, lk, 32'(s));
      end
    end
    d = longint'(o_scale) - 64'h000A_0000;
    if (d < 0) d = -d;
    vectors++;
    if (o_locked !== 1'b1 || d * 100 > 64'h000A_0000) begin
      miscompares++;
      $display("[TB] FAIL loop_converge: got locked=%b scale=%h, expected locked=1 scale within 1%% of 000a0000",
               o_locked, o_scale);
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit seen = 0;
    bit got;
    int cyc = 0;
    do_reset();
    i_stream_in = 16'd1000;
    i_target = 16'd1000;
    i_deadband = 16'd16;
    i_enable = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_scale_valid) seen = 1;
    end
    i_enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_scale_valid) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL abort_no_pulse: got a scale_valid pulse, expected none");
    end
    vectors++;
    if ({o_level, o_scale, o_locked} !== {16'd0, 32'h0001_0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs_kept: got level=%0d scale=%h locked=%b, expected 0 00010000 0",
               o_level, o_scale, o_locked);
    end
    i_enable = 1'b1;
    tick();
    got = 0;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      got = o_scale_valid;
    end
    vectors++;
    if (!got || cyc != PERIOD || o_level !== 16'd1000) begin
      miscompares++;
      $display("[TB] FAIL abort_resume: got %0d cycles level=%0d, expected %0d cycles level=1000",
               cyc, o_level, PERIOD);
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_hold_reset();
    int cyc;
    bit seen;
    do_reset();
    i_stream_in = 16'd500;
    i_target = 16'd1000;
    i_deadband = 16'd0;
    i_hold = 1'b1;
    i_enable = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
        tick();
        cyc++;
        seen = o_scale_valid;
      end
      vectors++;
      if (!seen || o_level !== 16'd500 || o_scale !== 32'h0001_0000 || o_locked !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_pulse[%0d]: got seen=%b level=%0d scale=%h locked=%b, expected 1 500 00010000 0",
                 p, seen, o_level, o_scale, o_locked);
      end
    end
    for (int c = 0; c < 10; c++) tick();
    i_rst = 1'b1;
    tick();
    vectors++;
    if ({o_scale, o_scale_valid, o_level, o_locked, o_at_min, o_at_max} !==
        {32'h0001_0000, 1'b0, 16'd0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL midwindow_reset: got scale=%h valid=%b level=%0d locked=%b min=%b max=%b, expected reset values",
               o_scale, o_scale_valid, o_level, o_locked, o_at_min, o_at_max);
    end
    i_rst = 1'b0;
    i_hold = 1'b0;
    tick();
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      tick();
      cyc++;
      seen = o_scale_valid;
    end
    vectors++;
    if (!seen || cyc != PERIOD || o_scale !== 32'(model_next(SCALE_INIT, 500, 1000, 0, 1'b0))) begin
      miscompares++;
      $display("[TB] FAIL post_reset_step: got %0d cycles scale=%h, expected %0d cycles scale=%h",
               cyc, o_scale, PERIOD, 32'(model_next(SCALE_INIT, 500, 1000, 0, 1'b0)));
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_random_windows();
    int     tgt;
    int     db;
    int     smp;
    int     sum;
    int     lvl;
    int     off;
    bit     hd;
    bit     lk;
    longint s;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      s = SCALE_INIT;
      tgt = int'($urandom_range(200, 12000));
      db = int'($urandom_range(0, tgt / 4));
      i_target = 16'(tgt);
      i_deadband = 16'(db);
      i_enable = 1'b1;
      tick();
      sum = 0;
      for (int c = 1; c <= PERIOD * 6; c++) begin
        smp = int'($urandom_range(0, 2 * tgt));
        if ($urandom_range(0, 1) == 1) smp = -smp;
        if ($urandom_range(0, 15) == 0) smp = -32768;
        hd = ($urandom_range(0, 3) == 0);
        i_stream_in = 16'(smp);
        i_hold = hd;
        tick();
        off = (c - 1) % PERIOD;
        if (off >= SETTLE_CYC && off < SETTLE_CYC + WIN) sum += model_abs(smp);
        if (c % PERIOD == 0) begin
          lvl = sum / WIN;
          lk = model_locked(lvl, tgt, db);
          s = model_next(s, lvl, tgt, db, hd);
          sum = 0;
          vectors++;
          if (o_scale_valid !== 1'b1 || o_level !== 16'(lvl) || o_locked !== lk || o_scale !== 32'(s)) begin
            miscompares++;
            $display("[TB] FAIL rand_decide[%0d/%0d]: got valid=%b level=%0d locked=%b scale=%h, expected 1 %0d %b %h",
                     seg, c, o_scale_valid, o_level, o_locked, o_scale, lvl, lk, 32'(s));
          end
        end else begin
          vectors++;
          if (o_scale_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand_idle_valid[%0d/%0d]: got valid=%b, expected 0", seg, c, o_scale_valid);
          end
        end
      end
      i_enable = 1'b0;
      i_hold = 1'b0;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lock();
    test_open_loop();
    test_min_clamp();
    test_closed_loop();
    test_abort();
    test_hold_reset();
    test_random_windows();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
